// File: rtl/calendar_pkg.sv
// Shared definitions for the BCD calendar counter.
//   - BCD month constants JAN..DEC
//   - bcd_valid         : nibble is a legal BCD digit
//   - is_leap_bcd       : leap-year test on a 4-digit BCD year
//   - days_in_month_bcd : last day of a month, returned as 2-digit BCD
//   - bcd2_inc/bcd2_dec : 2-digit BCD step helpers for day and month
package calendar_pkg;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    // Two BCD digits T,U are divisible by 4 exactly when
    // (T even and U in {0,4,8}) or (T odd and U in {2,6}).
    function automatic logic div4_bcd(input logic [7:0] tu);
        logic [3:0] u;
        u = tu[3:0];
        if (tu[4] == 1'b0)
            return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        else
            return (u == 4'd2) || (u == 4'd6);
    endfunction

    // Century years (low digits 00) fall back to the high digits under the
    // Gregorian rule, which is the same as "divisible by 400". Year 0000
    // passes either way.
    function automatic logic is_leap_bcd(input logic [15:0] year, input logic gregorian);
        if (gregorian && (year[7:0] == 8'h00))
            return div4_bcd(year[15:8]);
        else
            return div4_bcd(year[7:0]);
    endfunction

    // Unknown months report 31 so that an out-of-range day still reaches a
    // boundary and recovers on the next tick.
    function automatic logic [7:0] days_in_month_bcd(input logic [7:0] month, input logic leap);
        case (month)
            APR, JUN, SEP, NOV: return 8'h30;
            FEB:                return leap ? 8'h29 : 8'h28;
            default:            return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/calendar_counter_bcd_updown_digits.sv
// N-digit BCD up/down counter with synchronous load and enable.
//   clk, rst_n  : clock, async active-low reset (count = RST_VAL)
//   en_i        : step one count this cycle
//   down_i      : 0 count up, 1 count down
//   load_i      : load load_val_i (wins over en_i)
//   load_val_i  : BCD value to load
//   count_o     : current BCD count
//   wrap_o      : en_i & !load_i & count is at all-9s (up) / all-0s (down)
module bcd_updown_digits #(
    parameter int unsigned     N       = 4,
    parameter logic [4*N-1:0]  RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           down_i,
    input  logic           load_i,
    input  logic [4*N-1:0] load_val_i,
    output logic [4*N-1:0] count_o,
    output logic           wrap_o
);

    logic [4*N-1:0] count_q, count_d;
    logic           chain_end;

    // Ripple a carry/borrow from the least significant digit. A digit above
    // 9 is treated as the top of its range going up and clamps to 9 going
    // down, so a corrupted value recovers instead of locking up.
    always_comb begin
        logic       c;
        logic [3:0] dig;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        count_d = count_q;
        c       = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            dig = count_q[4*i +: 4];
            if (c) begin
                if (!down_i) begin
                    if (dig >= 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig = dig + 4'd1;
                        c   = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = 4'd9;
                    end else if (dig > 4'd9) begin
                        dig = 4'd9;
                        c   = 1'b0;
                    end else begin
                        dig = dig - 4'd1;
                        c   = 1'b0;
                    end
                end
            end
            if (en_i)
                count_d[4*i +: 4] = dig;
        end
        chain_end = c;
        if (load_i)
            count_d = load_val_i;
    end

    // NOTE: state registers use non-blocking assignments; only the state is
    // reset, the next-state logic is purely combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign wrap_o  = en_i & ~load_i & chain_end;

endmodule

// File: rtl/calendar_counter.sv
// BCD calendar date counter (YYYY-MM-DD) with up/down tick and validated load.
//   clk, rst_n  : clock, async active-low reset (date = RST_YEAR/MONTH/DAY)
//   tick        : advance one day (strobe), direction from down
//   down        : 0 increment, 1 decrement
//   load        : load ld_year/ld_month/ld_day (wins over tick)
//   ld_*        : BCD date to load; rejected if not a real date
//   year_bcd, month_bcd, day_bcd : current date
//   leapyear    : current year is a leap year (combinational)
//   carry_month : tick crosses a month boundary this cycle (combinational)
//   carry_year  : tick crosses a year boundary this cycle (combinational)
//   load_err    : previous cycle's load was rejected (registered pulse)
module calendar_counter
    import calendar_pkg::*;
#(
    parameter logic [15:0] RST_YEAR  = 16'h2019,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01,
    parameter bit          GREGORIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        down,
    input  logic        load,
    input  logic [15:0] ld_year,
    input  logic [7:0]  ld_month,
    input  logic [7:0]  ld_day,
    output logic [15:0] year_bcd,
    output logic [7:0]  month_bcd,
    output logic [7:0]  day_bcd,
    output logic        leapyear,
    output logic        carry_month,
    output logic        carry_year,
    output logic        load_err
);

    logic [7:0] day_q, day_d;
    logic [7:0] month_q, month_d;
    logic       load_err_q, load_err_d;

    logic       advance;
    logic [7:0] last_day;
    logic [7:0] prev_month;
    logic       at_first_day, at_last_day;
    logic       at_first_month, at_last_month;
    logic       ld_leap, ld_ok;
    logic [7:0] ld_last_day;
    logic       year_wrap_unused;

    assign leapyear = is_leap_bcd(year_bcd, GREGORIAN);
    assign last_day = days_in_month_bcd(month_q, leapyear);
    assign advance  = tick & ~load;

    // Magnitude compares on packed BCD keep digit ordering; using >= / <=
    // lets out-of-range values count as a boundary and recover.
    assign at_last_day    = day_q >= last_day;
    assign at_first_day   = day_q <= 8'h01;
    assign at_last_month  = month_q >= DEC;
    assign at_first_month = month_q <= JAN;

    assign carry_month = advance & (down ? at_first_day : at_last_day);
    assign carry_year  = carry_month & (down ? at_first_month : at_last_month);

    // Stepping back from January lands in December (always 31 days), so the
    // current year's leap flag is the right one whenever February is reached.
    assign prev_month = at_first_month ? DEC : bcd2_dec(month_q);

    assign ld_leap     = is_leap_bcd(ld_year, GREGORIAN);
    assign ld_last_day = days_in_month_bcd(ld_month, ld_leap);
    assign ld_ok = bcd_valid(ld_year[15:12]) & bcd_valid(ld_year[11:8])
                 & bcd_valid(ld_year[7:4])   & bcd_valid(ld_year[3:0])
                 & bcd_valid(ld_month[7:4])  & bcd_valid(ld_month[3:0])
                 & bcd_valid(ld_day[7:4])    & bcd_valid(ld_day[3:0])
                 & (ld_month >= JAN) & (ld_month <= DEC)
                 & (ld_day != 8'h00) & (ld_day <= ld_last_day);

    // Year only moves when the day/month pair rolls over the year boundary.
    bcd_updown_digits #(
        .N       (4),
        .RST_VAL (RST_YEAR)
    ) u_year (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (carry_year),
        .down_i     (down),
        .load_i     (load & ld_ok),
        .load_val_i (ld_year),
        .count_o    (year_bcd),
        .wrap_o     (year_wrap_unused)
    );

    always_comb begin
        day_d      = day_q;
        month_d    = month_q;
        load_err_d = 1'b0;
        if (load) begin
            load_err_d = ~ld_ok;
            if (ld_ok) begin
                day_d   = ld_day;
                month_d = ld_month;
            end
        end else if (tick) begin
            if (!down) begin
                if (at_last_day) begin
                    day_d   = 8'h01;
                    month_d = at_last_month ? JAN : bcd2_inc(month_q);
                end else begin
                    day_d = bcd2_inc(day_q);
                end
            end else begin
                if (at_first_day) begin
                    month_d = prev_month;
                    day_d   = days_in_month_bcd(prev_month, leapyear);
                end else begin
                    day_d = bcd2_dec(day_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q      <= RST_DAY;
            month_q    <= RST_MONTH;
            load_err_q <= 1'b0;
        end else begin
            day_q      <= day_d;
            month_q    <= month_d;
            load_err_q <= load_err_d;
        end
    end

    assign day_bcd   = day_q;
    assign month_bcd = month_q;
    assign load_err  = load_err_q;

endmodule
